// File: rtl/avl_cache.sv
// Direct-mapped, write-back, write-allocate cache shared by two Avalon-MM
// slave ports (s0 has fixed priority) in front of one bursting Avalon-MM
// master. One request is in flight at a time.
//
// Handshake: a slave request is taken on the rising edge where its
// request_ready is high and read or write is high; request_ready is only
// high in IDLE. A read answers with a one-cycle read_data_valid strobe. On
// the master side a command or burst word moves on every edge where the
// cache drives m0_read/m0_write and m0_request_ready is high; refill words
// are taken on every edge with m0_read_data_valid high.
module avl_cache #(
    parameter int SIZE       = 8192,
    parameter int BLOCK_SIZE = 256
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] s0_address,
    input  logic [3:0]  s0_byte_en,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [31:0] s0_write_data,
    output logic [31:0] s0_read_data,
    output logic        s0_read_data_valid,
    output logic        s0_request_ready,
    input  logic [31:0] s1_address,
    input  logic [3:0]  s1_byte_en,
    input  logic        s1_read,
    input  logic        s1_write,
    input  logic [31:0] s1_write_data,
    output logic [31:0] s1_read_data,
    output logic        s1_read_data_valid,
    output logic        s1_request_ready,
    output logic [31:0] m0_address,
    output logic [3:0]  m0_byte_en,
    output logic        m0_read,
    output logic        m0_write,
    output logic [31:0] m0_write_data,
    input  logic [31:0] m0_read_data,
    input  logic        m0_read_data_valid,
    input  logic        m0_request_ready,
    output logic        m0_begin_burst_transfer,
    output logic [7:0]  m0_burst_count
);
    localparam int LINES = SIZE / BLOCK_SIZE;
    localparam int WORDS = BLOCK_SIZE / 4;
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_WRITEBACK, ST_REFILL, ST_RESPOND
    } state_t;

    state_t             state_q, state_d;
    logic [29:0]        addr_q, addr_d;      // latched word address
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               port_q, port_d;      // 0 = s0, 1 = s1
    logic               wr_q, wr_d;
    logic [OFF_W-1:0]   cnt_q, cnt_d;        // burst word counter
    logic               cmd_done_q, cmd_done_d;
    logic               rdv0_q, rdv0_d, rdv1_q, rdv1_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;

    // Storage arrays are not reset: only the valid/dirty bits are.
    logic [31:0]        data_mem [LINES*WORDS];
    logic [TAG_W-1:0]   tag_mem [LINES];

    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic [TAG_W-1:0]   req_tag;
    logic               hit, s0_req, s1_req, finish_op;
    logic [31:0]        cur_word, merged;
    logic               mem_we, tag_we;
    logic [IDX_W+OFF_W-1:0] mem_waddr;
    logic [31:0]        mem_wdata;
    logic               unused_addr_lsbs;

    assign req_off   = addr_q[OFF_W-1:0];
    assign req_idx   = addr_q[OFF_W +: IDX_W];
    assign req_tag   = addr_q[29 -: TAG_W];
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign cur_word  = data_mem[{req_idx, req_off}];
    assign s0_req    = s0_read | s0_write;
    assign s1_req    = s1_read | s1_write;
    assign finish_op = ((state_q == ST_LOOKUP) && hit) || (state_q == ST_RESPOND);
    assign unused_addr_lsbs = ^{s0_address[1:0], s1_address[1:0]};

    // Merge the latched write data into the addressed word on enabled lanes.
    always_comb begin
        merged = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // Next-state logic: arbitration, lookup, write-back, refill, respond.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        cmd_done_d = cmd_done_q;
        rdv0_d     = 1'b0;
        rdv1_d     = 1'b0;
        rdata_d    = rdata_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        mem_we     = 1'b0;
        mem_waddr  = {req_idx, req_off};
        mem_wdata  = merged;
        tag_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // s0 always wins; a simultaneous read+write is a write.
                if (s0_req) begin
                    addr_d  = s0_address[31:2];
                    be_d    = s0_byte_en;
                    wdata_d = s0_write_data;
                    wr_d    = s0_write;
                    port_d  = 1'b0;
                    state_d = ST_LOOKUP;
                end else if (s1_req) begin
                    addr_d  = s1_address[31:2];
                    be_d    = s1_byte_en;
                    wdata_d = s1_write_data;
                    wr_d    = s1_write;
                    port_d  = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!hit) begin
                    cnt_d      = '0;
                    cmd_done_d = 1'b0;
                    state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (m0_request_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (!cmd_done_q) begin
                    if (m0_request_ready) cmd_done_d = 1'b1;
                end else if (m0_read_data_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = {req_idx, cnt_q};
                    mem_wdata = m0_read_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        state_d          = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: ;
            default: state_d = ST_IDLE;
        endcase
        // A hit in LOOKUP and the post-refill RESPOND finish identically.
        if (finish_op) begin
            if (wr_q) begin
                mem_we           = 1'b1;
                dirty_d[req_idx] = 1'b1;
            end else begin
                rdata_d = cur_word;
                rdv0_d  = ~port_q;
                rdv1_d  = port_q;
            end
            state_d = ST_IDLE;
        end
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            port_q     <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            cmd_done_q <= 1'b0;
            rdv0_q     <= 1'b0;
            rdv1_q     <= 1'b0;
            rdata_q    <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            cmd_done_q <= cmd_done_d;
            rdv0_q     <= rdv0_d;
            rdv1_q     <= rdv1_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    // Data and tag RAM writes; a reset cycle suppresses any pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !rest) data_mem[mem_waddr] <= mem_wdata;
        if (tag_we && !rest) tag_mem[req_idx] <= req_tag;
    end

    assign s0_request_ready   = !rest && (state_q == ST_IDLE);
    assign s1_request_ready   = !rest && (state_q == ST_IDLE) && !s0_req;
    assign s0_read_data       = rdata_q;
    assign s1_read_data       = rdata_q;
    assign s0_read_data_valid = !rest && rdv0_q;
    assign s1_read_data_valid = !rest && rdv1_q;

    assign m0_byte_en      = 4'hF;
    assign m0_burst_count  = 8'(WORDS);
    assign m0_write        = !rest && (state_q == ST_WRITEBACK);
    assign m0_read         = !rest && (state_q == ST_REFILL) && !cmd_done_q;
    assign m0_begin_burst_transfer = m0_read || (m0_write && (cnt_q == '0));
    assign m0_write_data   = data_mem[{req_idx, cnt_q}];
    assign m0_address      = (state_q == ST_WRITEBACK)
                           ? {tag_mem[req_idx], req_idx, {(OFF_W+2){1'b0}}}
                           : {req_tag, req_idx, {(OFF_W+2){1'b0}}};
endmodule

// File: tb/tb_avl_cache.sv
// Bench for avl_cache: a bursting memory slave on m0, directed scenarios,
// then random traffic on both ports checked against a flat byte memory.
module tb_avl_cache;
    localparam int MEM_WORDS = 8192;   // 32 KB backing store

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] s0_address, s0_write_data, s0_read_data;
    logic [3:0]  s0_byte_en;
    logic        s0_read, s0_write, s0_read_data_valid, s0_request_ready;
    logic [31:0] s1_address, s1_write_data, s1_read_data;
    logic [3:0]  s1_byte_en;
    logic        s1_read, s1_write, s1_read_data_valid, s1_request_ready;
    logic [31:0] m0_address, m0_write_data, m0_read_data;
    logic [3:0]  m0_byte_en;
    logic        m0_read, m0_write, m0_read_data_valid, m0_request_ready;
    logic        m0_begin_burst_transfer;
    logic [7:0]  m0_burst_count;

    avl_cache dut (
        .clk(clk), .rest(rest),
        .s0_address(s0_address), .s0_byte_en(s0_byte_en), .s0_read(s0_read),
        .s0_write(s0_write), .s0_write_data(s0_write_data), .s0_read_data(s0_read_data),
        .s0_read_data_valid(s0_read_data_valid), .s0_request_ready(s0_request_ready),
        .s1_address(s1_address), .s1_byte_en(s1_byte_en), .s1_read(s1_read),
        .s1_write(s1_write), .s1_write_data(s1_write_data), .s1_read_data(s1_read_data),
        .s1_read_data_valid(s1_read_data_valid), .s1_request_ready(s1_request_ready),
        .m0_address(m0_address), .m0_byte_en(m0_byte_en), .m0_read(m0_read),
        .m0_write(m0_write), .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
        .m0_read_data_valid(m0_read_data_valid), .m0_request_ready(m0_request_ready),
        .m0_begin_burst_transfer(m0_begin_burst_transfer), .m0_burst_count(m0_burst_count)
    );

    // Clock
    always #5 clk = ~clk;

    logic [31:0] back_mem [MEM_WORDS];       // memory behind m0
    logic [7:0]  ref_mem [MEM_WORDS*4];      // what s0/s1 must observe
    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    int          checks = 0;
    int          errors = 0;
    int          refill_cnt = 0, wb_start_cnt = 0, wb_done_cnt = 0;
    logic [31:0] last_rf_addr = 0, last_wb_addr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        base = int'(a[14:2]) * 4;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        int base;
        base = int'(a[14:2]) * 4;
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[base+b] = d[8*b +: 8];
    endtask

    task automatic sync_ref();
        for (int i = 0; i < MEM_WORDS; i++)
            for (int b = 0; b < 4; b++) ref_mem[i*4+b] = back_mem[i][8*b +: 8];
    endtask

    // Memory slave on m0: random ready, random refill pacing, burst checks.
    initial begin
        int rd_left, rd_ptr, wr_idx, wr_base;
        rd_left = 0; rd_ptr = 0; wr_idx = 0; wr_base = 0;
        m0_request_ready = 1'b0;
        m0_read_data_valid = 1'b0;
        m0_read_data = '0;
        forever begin
            @(negedge clk);
            #2;
            m0_read_data_valid = 1'b0;
            if (rest) begin
                rd_left = 0;
                wr_idx = 0;
                m0_request_ready = 1'b0;
            end else begin
                if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
                    m0_read_data_valid = 1'b1;
                    m0_read_data = back_mem[rd_ptr];
                    rd_ptr = (rd_ptr + 1) % MEM_WORDS;
                    rd_left--;
                end
                m0_request_ready = ($urandom_range(0, 3) != 0);
                if (m0_write && m0_request_ready) begin
                    check("wb_begin", 32'(m0_begin_burst_transfer), 32'(wr_idx == 0));
                    if (wr_idx == 0) begin
                        wr_base = int'(m0_address[14:2]);
                        last_wb_addr = m0_address;
                        wb_start_cnt++;
                        check("wb_burst_count", 32'(m0_burst_count), 32'd64);
                    end else begin
                        check("wb_addr_held", {17'd0, m0_address[14:0]}, 32'(wr_base * 4));
                    end
                    back_mem[wr_base + wr_idx] = m0_write_data;
                    wr_idx++;
                    if (wr_idx == 64) begin
                        wr_idx = 0;
                        wb_done_cnt++;
                    end
                end
                if (m0_read && m0_request_ready) begin
                    check("rf_begin", 32'(m0_begin_burst_transfer), 32'd1);
                    check("rf_burst_count", 32'(m0_burst_count), 32'd64);
                    rd_left = int'(m0_burst_count);
                    rd_ptr = int'(m0_address[14:2]);
                    last_rf_addr = m0_address;
                    refill_cnt++;
                end
            end
        end
    end

    // Driver: present a request, wait (bounded) for acceptance, update the model.
    task automatic issue(input int port, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        int n;
        logic rdy;
        @(negedge clk);
        if (port == 0) begin
            s0_address = addr; s0_byte_en = be; s0_write_data = data;
            s0_write = wr; s0_read = !wr;
        end else begin
            s1_address = addr; s1_byte_en = be; s1_write_data = data;
            s1_write = wr; s1_read = !wr;
        end
        #1;
        n = 0;
        rdy = (port == 0) ? s0_request_ready : s1_request_ready;
        while (!rdy && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
            rdy = (port == 0) ? s0_request_ready : s1_request_ready;
        end
        if (!rdy) begin
            check("accept_timeout", 32'(rdy), 32'd1);
        end else begin
            @(posedge clk);
            if (wr) ref_write(addr, be, data);
            else begin
                exp_q.push_back(ref_word(addr));
                mask_q.push_back(lane_mask(be));
            end
            @(negedge clk);
        end
        s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        #1;
    endtask

    // Scoreboard: wait for the strobe on the right port and compare enabled lanes.
    task automatic wait_resp(input int port, input int want_lat, output logic [31:0] got);
        int n;
        logic v, other;
        logic [31:0] e, m;
        got = '0;
        n = 1;
        v = (port == 0) ? s0_read_data_valid : s1_read_data_valid;
        while (!v && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
            v = (port == 0) ? s0_read_data_valid : s1_read_data_valid;
        end
        if (!v) begin
            check("resp_timeout", 32'(v), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m = mask_q.pop_front();
            end
            return;
        end
        other = (port == 0) ? s1_read_data_valid : s0_read_data_valid;
        got = (port == 0) ? s0_read_data : s1_read_data;
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        check("read_data", got & m, e & m);
        check("other_port_quiet", 32'(other), 32'd0);
        if (want_lat > 0) check("hit_latency", 32'(n), 32'(want_lat));
        @(negedge clk);
        #1;
        v = (port == 0) ? s0_read_data_valid : s1_read_data_valid;
        check("rdv_one_cycle", 32'(v), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got, orig, e;
        int rf0, wb0, wbd0, n;
        int port;
        bit wr;
        rest = 1'b1;
        s0_address = '0; s0_byte_en = '0; s0_read = 1'b0; s0_write = 1'b0; s0_write_data = '0;
        s1_address = '0; s1_byte_en = '0; s1_read = 1'b0; s1_write = 1'b0; s1_write_data = '0;
        for (int i = 0; i < MEM_WORDS; i++) back_mem[i] = $urandom;
        sync_ref();

        // Reset state, with a request pending that must not be acknowledged
        repeat (3) @(negedge clk);
        s0_read = 1'b1;
        #1;
        check("rst_s0_ready", 32'(s0_request_ready), 32'd0);
        check("rst_s1_ready", 32'(s1_request_ready), 32'd0);
        check("rst_rdv", 32'({s0_read_data_valid, s1_read_data_valid}), 32'd0);
        check("rst_m0", 32'({m0_read, m0_write, m0_begin_burst_transfer}), 32'd0);
        s0_read = 1'b0;
        @(negedge clk);
        rest = 1'b0;
        #1;
        check("ready_after_reset", 32'(s0_request_ready), 32'd1);

        // Cold read of 0x0
        rf0 = refill_cnt;
        issue(0, 1'b0, 32'h0, 4'hF, 32'h0);
        wait_resp(0, 0, got);
        check("cold_refills", 32'(refill_cnt - rf0), 32'd1);
        check("cold_refill_addr", last_rf_addr, 32'h0);
        check("cold_data", got, back_mem[0]);

        // Partial write then hit read of 0x104
        orig = back_mem[32'h104 >> 2];
        issue(1, 1'b1, 32'h104, 4'h3, 32'hA5A5A5A5);
        issue(1, 1'b0, 32'h104, 4'hF, 32'h0);
        rf0 = refill_cnt;
        wb0 = wb_start_cnt;
        wait_resp(1, 2, got);
        check("partial_low", {16'd0, got[15:0]}, 32'h0000A5A5);
        check("partial_high", {16'd0, got[31:16]}, {16'd0, orig[31:16]});
        check("hit_no_refill", 32'(refill_cnt - rf0), 32'd0);
        check("hit_no_wb", 32'(wb_start_cnt - wb0), 32'd0);

        // Dirty eviction: write 0x10, read conflicting 0x2010
        issue(0, 1'b1, 32'h10, 4'hF, 32'h12345678);
        wbd0 = wb_done_cnt;
        rf0 = refill_cnt;
        issue(0, 1'b0, 32'h2010, 4'hF, 32'h0);
        wait_resp(0, 0, got);
        check("evict_wb_bursts", 32'(wb_done_cnt - wbd0), 32'd1);
        check("evict_wb_addr", last_wb_addr, 32'h0);
        check("evict_wb_word4", back_mem[4], 32'h12345678);
        check("evict_refills", 32'(refill_cnt - rf0), 32'd1);
        check("evict_refill_addr", last_rf_addr, 32'h2000);

        // Reset in the middle of a write-back burst drops the dirty line
        orig = back_mem[32'h2020 >> 2];
        issue(0, 1'b1, 32'h2020, 4'hF, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h0020, 4'hF, 32'h0);
        exp_q.delete();
        mask_q.delete();
        n = 0;
        while (!m0_write && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_wb_started", 32'(m0_write), 32'd1);
        repeat (3) @(negedge clk);
        rest = 1'b1;
        #1;
        check("abort_m0_quiet", 32'({m0_write, m0_read, m0_begin_burst_transfer}), 32'd0);
        check("abort_ready_low", 32'(s0_request_ready), 32'd0);
        repeat (2) @(negedge clk);
        rest = 1'b0;
        #1;
        check("abort_ready_back", 32'(s0_request_ready), 32'd1);
        sync_ref();
        issue(0, 1'b0, 32'h2020, 4'hF, 32'h0);
        wait_resp(0, 0, got);
        check("abort_dirty_lost", got, orig);

        // Simultaneous s0/s1 requests (both hit line 0x2000)
        @(negedge clk);
        s0_address = 32'h2024; s0_byte_en = 4'hF; s0_read = 1'b1;
        s1_address = 32'h2028; s1_byte_en = 4'hF; s1_read = 1'b1;
        #1;
        check("arb_s0_ready", 32'(s0_request_ready), 32'd1);
        check("arb_s1_held", 32'(s1_request_ready), 32'd0);
        @(posedge clk);
        exp_q.push_back(ref_word(32'h2024));
        mask_q.push_back(32'hFFFFFFFF);
        @(negedge clk);
        s0_read = 1'b0;
        #1;
        check("arb_s1_wait_lookup", 32'(s1_request_ready), 32'd0);
        @(negedge clk);
        #1;
        check("arb_s1_next_idle", 32'(s1_request_ready), 32'd1);
        check("arb_s0_rdv", 32'(s0_read_data_valid), 32'd1);
        e = exp_q.pop_front();
        void'(mask_q.pop_front());
        check("arb_s0_data", s0_read_data, e);
        @(posedge clk);
        exp_q.push_back(ref_word(32'h2028));
        mask_q.push_back(32'hFFFFFFFF);
        @(negedge clk);
        s1_read = 1'b0;
        #1;
        wait_resp(1, 2, got);

        // Random mixed traffic over 32 KB on both ports
        for (int i = 0; i < 250; i++) begin
            port = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            issue(port, wr, 32'($urandom_range(0, MEM_WORDS - 1)) << 2,
                  4'($urandom_range(1, 15)), $urandom);
            if (!wr) wait_resp(port, 0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
